sdram_port_arbiter: RTL and testbench

//  Shares one SDRAM controller command port among NPORT requesters (e.g. test pattern

---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_rr.sv | 18 +
 rtl/sdram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick function for the SDRAM port arbiter.
// Used by sdram_arb_rr and sdram_port_arbiter.
package sdram_arb_pkg;

  localparam int NPORT_MAX = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RDWAIT  = 2'd2,
    REFRESH = 2'd3
  } arb_state_t;

  // Scan last+1, last+2, ... mod nport; the nearest asserted request wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NPORT_MAX-1:0] req,
                                               input logic [IDX_W-1:0]     last,
                                               input int                   nport);
    logic [IDX_W-1:0] pick;
    int cand;
    pick = last;
    for (int k = NPORT_MAX; k >= 1; k--) begin
      if (k <= nport) begin
        cand = (int'(last) + k) % nport;
        if (req[IDX_W'(cand)]) pick = IDX_W'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Combinational round-robin picker: the port after 'last' with a request wins.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter int NPORT = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = rr_pick(NPORT_MAX'(req), last, NPORT);
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among NPORT clients, one command in flight.
// Optional periodic refresh insertion when SDRAM_ARB_REFRESH_EN is defined.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int T_RI  = 1900
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  wr,
  input  logic [NPORT*AW-1:0] addr,
  input  logic [NPORT*DW-1:0] wdata,
  output logic [NPORT-1:0]  ack,
  output logic [NPORT-1:0]  rvalid,
  output logic [DW-1:0]     rdata,
  output logic              ctl_req,
  output logic              ctl_wr,
  output logic [AW-1:0]     ctl_addr,
  output logic [DW-1:0]     ctl_wdata,
  output logic              ctl_refresh,
  input  logic              ctl_ack,
  input  logic              ctl_rvalid,
  input  logic [DW-1:0]     ctl_rdata
);

  if (NPORT < 2 || NPORT > NPORT_MAX || T_RI < 2) begin : g_cfg_check
    $error("sdram_port_arbiter: unsupported parameter set");
  end

  logic              wr_a    [NPORT_MAX];
  logic [AW-1:0]     addr_a  [NPORT_MAX];
  logic [DW-1:0]     wdata_a [NPORT_MAX];

  for (genvar i = 0; i < NPORT_MAX; i++) begin : g_unpack
    if (i < NPORT) begin : g_port
      assign wr_a[i]    = wr[i];
      assign addr_a[i]  = addr[i*AW +: AW];
      assign wdata_a[i] = wdata[i*DW +: DW];
    end else begin : g_pad
      assign wr_a[i]    = 1'b0;
      assign addr_a[i]  = '0;
      assign wdata_a[i] = '0;
    end
  end

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_last;
  logic [IDX_W-1:0]  owner;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [NPORT-1:0]  req_live;

  // A client sees its ack one cycle late, so its req is still up in the ack cycle.
  assign req_live = req & ~ack;

  sdram_arb_rr #(.NPORT(NPORT)) u_rr (
    .req   (req_live),
    .last  (rr_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int CW = $clog2(T_RI);

  logic [CW-1:0] ref_cnt;
  logic          ref_pending;
  logic          ref_done;

  assign ref_done = (state == REFRESH) && ctl_ack;

  // Free-running interval timer; a new pending request wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else if (ref_cnt == CW'(T_RI - 1)) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (ref_done) ref_pending <= 1'b0;
    end
  end
`else
  assign ctl_refresh = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= IDX_W'(NPORT - 1);
      owner     <= '0;
      ack       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      ctl_req   <= 1'b0;
      ctl_wr    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
      ctl_refresh <= 1'b0;
`endif
    end else begin
      ack    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
          if (ref_pending) begin
            ctl_refresh <= 1'b1;
            state       <= REFRESH;
          end else
`endif
          if (pick_valid) begin
            owner     <= pick_idx;
            rr_last   <= pick_idx;
            ctl_req   <= 1'b1;
            ctl_wr    <= wr_a[pick_idx];
            ctl_addr  <= addr_a[pick_idx];
            ctl_wdata <= wdata_a[pick_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (ctl_ack) begin
            ctl_req <= 1'b0;
            ack     <= NPORT'(32'(1) << owner);
            state   <= ctl_wr ? IDLE : RDWAIT;
          end
        end
        RDWAIT: begin
          if (ctl_rvalid) begin
            rdata  <= ctl_rdata;
            rvalid <= NPORT'(32'(1) << owner);
            state  <= IDLE;
          end
        end
`ifdef SDRAM_ARB_REFRESH_EN
        REFRESH: begin
          if (ctl_ack) begin
            ctl_refresh <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: client and controller models plus an output monitor.
// Build with SDRAM_ARB_REFRESH_EN defined to exercise refresh insertion.
module tb_sdram_port_arbiter;

  localparam int NPORT = 2;
  localparam int AW    = 22;
  localparam int DW    = 16;
  localparam int T_RI  = 16;

  typedef struct packed {
    logic [1:0]    port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NPORT-1:0]  req;
  logic [NPORT-1:0]  wr;
  logic [NPORT*AW-1:0] addr;
  logic [NPORT*DW-1:0] wdata;
  logic [NPORT-1:0]  ack;
  logic [NPORT-1:0]  rvalid;
  logic [DW-1:0]     rdata;
  logic              ctl_req;
  logic              ctl_wr;
  logic [AW-1:0]     ctl_addr;
  logic [DW-1:0]     ctl_wdata;
  logic              ctl_refresh;
  logic              ctl_ack;
  logic              ctl_rvalid;
  logic [DW-1:0]     ctl_rdata;

  int checks = 0;
  int passed = 0;

  cmd_t client_q [NPORT][$];
  cmd_t exp_q[$];
  cmd_t cur;
  logic in_issue = 1'b0;
  logic rd_wait  = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  int ack_delay = 2;
  int rd_delay  = 3;
  int stray_req  = 0;
  int stray_done = 0;

  int cycle = 0;
  int refr_count = 0;
  int refr_intervals = 0;
  int last_refr = -1;
  logic refr_track = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .T_RI(T_RI)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ctl_req     (ctl_req),
    .ctl_wr      (ctl_wr),
    .ctl_addr    (ctl_addr),
    .ctl_wdata   (ctl_wdata),
    .ctl_refresh (ctl_refresh),
    .ctl_ack     (ctl_ack),
    .ctl_rvalid  (ctl_rvalid),
    .ctl_rdata   (ctl_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] onehot(input logic [1:0] p);
    return 32'(1) << p;
  endfunction

  // Controller memory contents as seen by reads
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 22'h0000AA) return 16'h1234;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic applyStimulus(input int p, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    cmd_t c;
    c.port  = 2'(p);
    c.wr    = w;
    c.addr  = a;
    c.wdata = d;
    client_q[p].push_back(c);
    exp_q.push_back(c);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0 || client_q[0].size() > 0 || client_q[1].size() > 0 ||
            req != '0 || in_issue || rd_wait) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(n < 500), 1);
    repeat (2) @(negedge clk);
  endtask

  // Clients: hold req until ack, then drop it or present the next queued command
  initial begin
    cmd_t c;
    req = '0; wr = '0; addr = '0; wdata = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NPORT; p++) begin
        if (reset) req[p] = 1'b0;
        else begin
          if (req[p] && ack[p]) req[p] = 1'b0;
          if (!req[p] && client_q[p].size() > 0) begin
            c = client_q[p].pop_front();
            req[p] = 1'b1;
            wr[p]  = c.wr;
            addr[p*AW +: AW]  = c.addr;
            wdata[p*DW +: DW] = c.wdata;
          end
        end
      end
    end
  end

  // Controller: acks after ack_delay, returns read data rd_delay after the ack
  initial begin
    logic is_rd;
    logic [AW-1:0] a;
    ctl_ack = 1'b0; ctl_rvalid = 1'b0; ctl_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        ctl_rdata = 16'hDEAD;
        ctl_rvalid = 1'b1;
        @(negedge clk);
        ctl_rvalid = 1'b0;
        stray_done++;
      end else if (!reset && (ctl_req || ctl_refresh)) begin
        is_rd = ctl_req && !ctl_wr;
        a = ctl_addr;
        repeat (ack_delay - 1) @(negedge clk);
        ctl_ack = 1'b1;
        @(negedge clk);
        ctl_ack = 1'b0;
        if (is_rd) begin
          repeat (rd_delay - 1) @(negedge clk);
          ctl_rdata = rd_model(a);
          ctl_rvalid = 1'b1;
          @(negedge clk);
          ctl_rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: sampled just after each rising edge
  initial begin
    logic req_prev = 1'b0;
    logic refr_prev = 1'b0;
    logic [DW-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (reset) begin
        in_issue = 1'b0; rd_wait = 1'b0; req_prev = 1'b0; refr_prev = 1'b0;
      end else begin
        if (ctl_req && !req_prev) begin
          if (exp_q.size() == 0) checkOutput("unexpected_cmd", 1, 0);
          else begin
            cur = exp_q.pop_front();
            checkOutput("ctl_wr", 32'(ctl_wr), 32'(cur.wr));
            checkOutput("ctl_addr", 32'(ctl_addr), 32'(cur.addr));
            checkOutput("ctl_wdata", 32'(ctl_wdata), 32'(cur.wdata));
            in_issue = 1'b1;
          end
        end
        if (ctl_ack && in_issue) begin
          checkOutput("ack", 32'(ack), onehot(cur.port));
          in_issue = 1'b0;
          rd_wait = !cur.wr;
        end else if (ack != '0) checkOutput("stray_ack", 32'(ack), 0);
        if (ctl_rvalid && rd_wait) begin
          d = rd_model(cur.addr);
          checkOutput("rvalid", 32'(rvalid), onehot(cur.port));
          checkOutput("rdata", 32'(rdata), 32'(d));
          last_rdata = d;
          rd_wait = 1'b0;
        end else if (rvalid != '0) checkOutput("stray_rvalid", 32'(rvalid), 0);
        if (ctl_refresh && !refr_prev) begin
          refr_count++;
          checkOutput("refresh_vs_req", 32'(ctl_req), 0);
          if (refr_track) begin
            if (last_refr >= 0) begin
              checkOutput("refresh_period", 32'(cycle - last_refr), T_RI);
              refr_intervals++;
            end
            last_refr = cycle;
          end
        end
        req_prev = ctl_req;
        refr_prev = ctl_refresh;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int refr_before;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_rvalid", 32'(rvalid), 0);
    checkOutput("rst_ctl_req", 32'(ctl_req), 0);
    checkOutput("rst_ctl_refresh", 32'(ctl_refresh), 0);
    checkOutput("rst_ctl_wr", 32'(ctl_wr), 0);
    checkOutput("rst_ctl_addr", 32'(ctl_addr), 0);
    checkOutput("rst_ctl_wdata", 32'(ctl_wdata), 0);
    checkOutput("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;

    $display("[TB] single write on port 0");
    applyStimulus(0, 1'b1, 22'h000123, 16'hBEEF);
    wait_drain();

    $display("[TB] read on port 1");
    applyStimulus(1, 1'b0, 22'h0000AA, 16'h0000);
    wait_drain();

    $display("[TB] fairness with both ports requesting");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'((k + 1) % 2), 22'(32'h100 + k), 16'(32'hA000 + k));
      applyStimulus(1, 1'(k % 2), 22'(32'h200 + k), 16'(32'hB000 + k));
    end
    refr_before = refr_count;
    wait_drain();
`ifdef SDRAM_ARB_REFRESH_EN
    checkOutput("refresh_between", 32'(refr_count > refr_before), 1);

    $display("[TB] idle refresh cadence");
    refr_track = 1'b1;
    last_refr = -1;
    repeat (70) @(negedge clk);
    refr_track = 1'b0;
    checkOutput("refresh_intervals", 32'(refr_intervals >= 3), 1);
`else
    repeat (40) @(negedge clk);
    checkOutput("no_refresh", 32'(refr_count - refr_before), 0);
`endif

    $display("[TB] reset while waiting for read data");
    rd_delay = 8;
    applyStimulus(0, 1'b0, 22'h0003C0, 16'h0000);
    begin
      int n = 0;
      while (!rd_wait && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("rst_setup", 32'(rd_wait), 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_ctl_req", 32'(ctl_req), 0);
    checkOutput("midrst_rvalid", 32'(rvalid), 0);
    checkOutput("midrst_rdata", 32'(rdata), 0);
    last_rdata = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("midrst_late_rvalid", 32'(rvalid), 0);
      checkOutput("midrst_late_rdata", 32'(rdata), 0);
    end
    rd_delay = 3;
    applyStimulus(0, 1'b0, 22'h000055, 16'h0000);
    applyStimulus(1, 1'b1, 22'h000077, 16'hC0DE);
    wait_drain();

    $display("[TB] stray controller read data in idle");
    stray_req++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("stray_rvalid_idle", 32'(rvalid), 0);
      checkOutput("stray_rdata_idle", 32'(rdata), 32'(last_rdata));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
